// File: rtl/hamming_pkg.sv
// Shared types and default job geometry for the Hamming SECDED encode sequencer.
package hamming_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } hamseq_state_e;

    typedef logic [15:0] hamming_cw_t;
    typedef logic [10:0] hamming_msg_t;

    localparam int unsigned DEF_SRC_BASE = 0;
    localparam int unsigned DEF_DST_BASE = 30;
    localparam int unsigned DEF_NUM_MSG  = 15;
    localparam int unsigned DEF_AW       = 8;

endpackage

// File: rtl/hamming_enc.sv
// Combinational SECDED encoder: 11-bit message d[11:1] -> 16-bit codeword.
module hamming_enc
    import hamming_pkg::*;
(
    input  hamming_msg_t i_data,
    output hamming_cw_t  o_cw
);

    logic [11:1] w_d;
    logic        w_p8;
    logic        w_p4;
    logic        w_p2;
    logic        w_p1;
    logic        w_p0;

    assign w_d  = i_data;
    assign w_p8 = ^w_d[11:5];
    assign w_p4 = (^w_d[11:8]) ^ (^w_d[4:2]);
    assign w_p2 = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
    assign w_p1 = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
    // Overall parity covers every data and check bit, giving double-error detection.
    assign w_p0 = (^w_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;

    assign o_cw = {w_d[11:5], w_p8, w_d[4:2], w_p4, w_d[1], w_p2, w_p1, w_p0};

endmodule

// File: rtl/hamming_seq.sv
// Program-1 Hamming encode sequencer: owns the data-memory port while busy.
// Optional source-format check enabled by defining HAMSEQ_FMTCHK_EN.
module hamming_seq
    import hamming_pkg::*;
#(
    parameter int unsigned SRC_BASE = DEF_SRC_BASE,
    parameter int unsigned DST_BASE = DEF_DST_BASE,
    parameter int unsigned NUM_MSG  = DEF_NUM_MSG,
    parameter int unsigned AW       = DEF_AW
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

    hamseq_state_e r_state;
    logic [6:0]    r_idx;
    logic [7:0]    r_lo;
    logic [2:0]    r_hi;
    logic          r_busy;
    logic          r_done;

    logic [AW-1:0] w_off;
    logic [AW-1:0] w_src_addr;
    logic [AW-1:0] w_dst_addr;
    hamming_cw_t   w_cw;

    assign w_off      = AW'({r_idx, 1'b0});
    assign w_src_addr = AW'(SRC_BASE) + w_off;
    assign w_dst_addr = AW'(DST_BASE) + w_off;

    hamming_enc u_enc (
        .i_data ({r_hi, r_lo}),
        .o_cw   (w_cw)
    );

`ifdef HAMSEQ_FMTCHK_EN
    logic r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign cpu_stall = r_busy;
    assign cpu_rdata = mem_rdata;

    // Port mux is combinational so an async reset returns the port to the core at once.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        case (r_state)
            ST_RD_LO: begin
                mem_addr  = w_src_addr;
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
            ST_RD_HI: begin
                mem_addr  = w_src_addr + AW'(1);
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
            ST_WR_LO: begin
                mem_addr  = w_dst_addr;
                mem_we    = 1'b1;
                mem_wdata = w_cw[7:0];
            end
            ST_WR_HI: begin
                mem_addr  = w_dst_addr + AW'(1);
                mem_we    = 1'b1;
                mem_wdata = w_cw[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef HAMSEQ_FMTCHK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RD_LO;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
`ifdef HAMSEQ_FMTCHK_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                ST_RD_LO: begin
                    r_lo    <= mem_rdata;
                    r_state <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    r_hi    <= mem_rdata[2:0];
                    r_state <= ST_WR_LO;
`ifdef HAMSEQ_FMTCHK_EN
                    if (mem_rdata[7:3] != 5'd0) begin
                        r_err <= 1'b1;
                    end
`endif
                end
                ST_WR_LO: begin
                    r_state <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    r_idx <= r_idx + 7'd1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RD_LO;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hamming_seq.md
# hamming_seq

Hardware sequencer for the program-1 Hamming (SECDED) encode job. It walks the source message area of the byte-wide data memory, encodes each 11-bit message into a 16-bit codeword, and writes the codeword to the destination area. While it runs it owns the single data-memory port and stalls the core; when idle it passes the core's memory requests straight through. It sits between `top_level`'s core and `dm1`, and drives the core-visible `done`.

## Interface
- `SRC_BASE`, 0: byte address of message 0 low byte.
- `DST_BASE`, 30: byte address of codeword 0 low byte.
- `NUM_MSG`, 15: messages per job, 1..127.
- `AW`, 8: memory address width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE/DONE only.
- `busy` out 1: job in progress.
- `done` out 1: job complete, level.
- `err` out 1: sticky format error (see Configuration).
- `cpu_addr` in AW, `cpu_we` in 1, `cpu_wdata` in 8: core memory request.
- `cpu_rdata` out 8: read data to core (= `mem_rdata`).
- `cpu_stall` out 1: core request not serviced this cycle (= `busy`).
- `mem_addr` out AW, `mem_we` out 1, `mem_wdata` out 8: data-memory port.
- `mem_rdata` in 8: combinational read data for `mem_addr`.

## Operation
- Message i: source bytes `SRC_BASE+2i` (d[8:1]) and `SRC_BASE+2i+1` (bits 2:0 = d[11:9]); destination bytes `DST_BASE+2i` (cw[7:0]) and `DST_BASE+2i+1` (cw[15:8]).
- Codeword cw[15:0] = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
- p8 = ^d[11:5]; p4 = ^d[11:8] ^ ^d[4:2]; p2 = d11^d10^d7^d6^d4^d3^d1; p1 = d11^d9^d7^d5^d4^d2^d1; p0 = ^d[11:1]^p8^p4^p2^p1.
- FSM: IDLE -> RD_LO -> RD_HI -> WR_LO -> WR_HI -> (RD_LO if i<NUM_MSG-1, else DONE). DONE -> RD_LO on `start`, else hold.
- RD_LO/RD_HI: drive source address, capture `mem_rdata` into lo/hi registers at cycle end.
- WR_LO/WR_HI: drive destination address, `mem_we`=1, `mem_wdata` = cw byte.
- Message index i: 7-bit counter, cleared on accepted `start`, incremented on leaving WR_HI.
- Port mux: IDLE/DONE -> `mem_*` = `cpu_*`; other states -> sequencer drives, `cpu_we` gated off, core reads return sequencer traffic and must be ignored (stalled).
- `start` while busy: ignored, no queueing.

## Timing
- Reset values: FSM IDLE, i=0, `busy`=0, `done`=0, `err`=0, `mem_we` follows `cpu_we` (pass-through).
- `start` high at cycle N (in IDLE/DONE) -> RD_LO at N+1; 4 cycles/message; final WR_HI at N+4·NUM_MSG; `busy` high N+1..N+4·NUM_MSG; `done` high from N+4·NUM_MSG+1.
- Default: 60 busy cycles, `done` at N+61.
- `done` held until next accepted `start` (drops same edge `busy` rises) or reset.
- Reset mid-job: immediate return to IDLE, `mem_we` deasserted without waiting for a clock; completed bytes stay in memory, no roll-back.
- `start` and reset simultaneous: reset wins.

## Configuration
- `HAMSEQ_FMTCHK_EN` defined: when a captured high source byte has any of bits 7:3 set, `err` sets (sticky until next accepted `start` or reset); encoding uses bits 2:0 only, job continues.
- Undefined: bits 7:3 silently ignored, `err` tied 0.

## Structure
- Package `hamming_pkg`: FSM state enum, `hamming_cw_t` (16-bit) typedef, default base/count localparams.
- Sub-module `hamming_enc`: combinational 11-bit -> 16-bit encoder, reusable by the program-2 decoder bench.

## Test plan
- Reset then `start`, messages d=11'h000, 11'h001, 11'h7FF -> destination words 16'h0000, 16'h000F, 16'hFFFF; `done` exactly 61 cycles after `start`.
- 15 random messages -> all 30 destination bytes match encoder model; source bytes unchanged.
- Core writes 8'hA5 to address 100 while busy -> not written, `cpu_stall`=1; same write in DONE -> written.
- `reset_n` low at cycle 20 of a job -> `busy`/`done` 0 immediately; messages 0..4 written, message 5+ destinations untouched; new `start` completes normally.
- `start` pulsed again at cycle 10 of a job -> ignored, `done` still at cycle 61.
- With `HAMSEQ_FMTCHK_EN`, source hi byte 8'hF9 -> `err`=1, codeword uses d[11:9]=3'b001; without the macro `err` stays 0.
